// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board defaults, move-engine states and column/row types.
package connect4_pkg;

    localparam int unsigned ROWS_DEF = 6;
    localparam int unsigned COLS_DEF = 7;

    typedef enum logic [1:0] {
        SELECT = 2'd0,
        WRITE  = 2'd1,
        SWITCH = 2'd2,
        FULL   = 2'd3
    } state_e;

    typedef logic [$clog2(COLS_DEF)-1:0] col_t;
    typedef logic [$clog2(ROWS_DEF)-1:0] row_t;

endpackage

// File: rtl/control_columna_if.sv
// Board-memory write channel: valid/ready handshake carrying row, column and piece owner.
interface control_columna_if #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 7
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [$clog2(ROWS)-1:0] wr_row;
    logic [$clog2(COLS)-1:0] wr_col;
    logic                    wr_player;

    modport master (
        output wr_valid,
        output wr_row,
        output wr_col,
        output wr_player,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_row,
        input  wr_col,
        input  wr_player,
        output wr_ready
    );
endinterface

// File: rtl/column_heights.sv
// Per-column fill heights, column-full flags and total piece count for the move engine.
module column_heights
    import connect4_pkg::*;
#(
    parameter  int unsigned ROWS = ROWS_DEF,
    parameter  int unsigned COLS = COLS_DEF,
    localparam int unsigned CW   = $clog2(COLS),
    localparam int unsigned HW   = $clog2(ROWS + 1),
    localparam int unsigned NW   = $clog2(ROWS * COLS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic [CW-1:0]            col,
    output logic [COLS-1:0][HW-1:0]  heights,
    output logic [COLS-1:0]          col_full,
    output logic [NW-1:0]            count
);

    logic [COLS-1:0][HW-1:0] r_height;
    logic [NW-1:0]           r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_height <= '0;
            r_count  <= '0;
        end else if (inc) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (col == CW'(c)) begin
                    r_height[c] <= r_height[c] + HW'(1);
                end
            end
            r_count <= r_count + NW'(1);
        end
    end

    always_comb begin
        col_full = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            col_full[c] = (r_height[c] == HW'(ROWS));
        end
    end

    assign heights = r_height;
    assign count   = r_count;

endmodule

// File: rtl/control_columna.sv
// Connect-4 move engine: column cursor, drop requests over the write channel and turn hand-off.
// Optional turn timeout is enabled by defining TURN_TIMEOUT_EN.
module control_columna
    import connect4_pkg::*;
#(
    parameter int unsigned ROWS           = ROWS_DEF,
    parameter int unsigned COLS           = COLS_DEF,
    parameter int unsigned START_COL      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      press_izq,
    input  logic                      press_der,
    input  logic                      press_ent,
    input  logic                      jugada,
    output logic                      btn_enable,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      player,
    control_columna_if.master         wr,
    output logic [COLS-1:0]           col_full,
    output logic                      drop_err,
    output logic                      turn_done,
`ifdef TURN_TIMEOUT_EN
    output logic                      timeout,
`endif
    output logic                      board_full
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned HW = $clog2(ROWS + 1);
    localparam int unsigned NW = $clog2(ROWS * COLS + 1);

    state_e                  r_state, w_state_next;
    logic [CW-1:0]           r_cursor, w_cursor_next;
    logic                    r_player;
    logic                    r_wr_valid;
    logic [RW-1:0]           r_wr_row;
    logic [CW-1:0]           r_wr_col;
    logic                    r_wr_player;
    logic                    r_drop_err;
    logic                    r_turn_done;
    logic                    r_board_full;

    logic [COLS-1:0][HW-1:0] w_heights;
    logic [COLS-1:0]         w_col_full;
    logic [NW-1:0]           w_count;

    logic w_sel, w_izq, w_der, w_ent, w_ent_ok, w_ent_full, w_hs, w_tmo_hit;

    column_heights #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_heights (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_hs),
        .col      (r_wr_col),
        .heights  (w_heights),
        .col_full (w_col_full),
        .count    (w_count)
    );

    // Press decode with izq > der > ent priority, only while a move can be taken.
    always_comb begin
        w_sel      = (r_state == SELECT) & jugada;
        w_izq      = w_sel & press_izq;
        w_der      = w_sel & press_der & ~press_izq;
        w_ent      = w_sel & press_ent & ~press_izq & ~press_der;
        w_ent_full = w_ent & w_col_full[r_cursor];
        w_ent_ok   = w_ent & ~w_col_full[r_cursor];
        w_hs       = (r_state == WRITE) & r_wr_valid & wr.wr_ready;
    end

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_pend;
    logic          r_timeout;

    assign w_tmo_hit = (r_state == SELECT) & ~(w_izq | w_der | w_ent) &
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt  <= '0;
            r_tmo_pend <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state != SELECT || w_izq || w_der || w_ent || w_tmo_hit) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
            if (w_tmo_hit) begin
                r_tmo_pend <= 1'b1;
            end else if (r_state == SWITCH) begin
                r_tmo_pend <= 1'b0;
            end
            r_timeout <= (r_state == SWITCH) & r_tmo_pend;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SELECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cursor_next = r_cursor;
        case (r_state)
            SELECT: begin
                if (w_ent_ok) begin
                    w_state_next = WRITE;
                end else if (w_tmo_hit) begin
                    w_state_next = SWITCH;
                end
            end
            WRITE: begin
                if (w_hs) begin
                    w_state_next = SWITCH;
                end
            end
            SWITCH: begin
                w_state_next = (w_count == NW'(ROWS * COLS)) ? FULL : SELECT;
            end
            FULL: begin
                w_state_next = FULL;
            end
            default: begin
                w_state_next = SELECT;
            end
        endcase

        if (w_izq) begin
            w_cursor_next = (r_cursor == '0) ? CW'(COLS - 1) : r_cursor - CW'(1);
        end else if (w_der) begin
            w_cursor_next = (r_cursor == CW'(COLS - 1)) ? '0 : r_cursor + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cursor     <= CW'(START_COL);
            r_player     <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_row     <= '0;
            r_wr_col     <= '0;
            r_wr_player  <= 1'b0;
            r_drop_err   <= 1'b0;
            r_turn_done  <= 1'b0;
            r_board_full <= 1'b0;
        end else begin
            r_cursor    <= w_cursor_next;
            r_drop_err  <= w_ent_full;
            r_turn_done <= (r_state == SWITCH);
            if (r_state == SWITCH) begin
                r_player <= ~r_player;
            end
            if (r_state == SWITCH && w_state_next == FULL) begin
                r_board_full <= 1'b1;
            end
            // Request fields are captured once and held until the handshake completes.
            if (w_ent_ok) begin
                r_wr_valid  <= 1'b1;
                r_wr_row    <= w_heights[r_cursor][RW-1:0];
                r_wr_col    <= r_cursor;
                r_wr_player <= r_player;
            end else if (w_hs) begin
                r_wr_valid  <= 1'b0;
            end
        end
    end

    assign btn_enable   = (r_state == SELECT);
    assign cursor_col   = r_cursor;
    assign player       = r_player;
    assign col_full     = w_col_full;
    assign drop_err     = r_drop_err;
    assign turn_done    = r_turn_done;
    assign board_full   = r_board_full;
    assign wr.wr_valid  = r_wr_valid;
    assign wr.wr_row    = r_wr_row;
    assign wr.wr_col    = r_wr_col;
    assign wr.wr_player = r_wr_player;

endmodule

// File: tb/tb_control_columna.sv
// Self-checking bench for control_columna: directed steps plus a randomized game against a board model.
module tb_control_columna;
    import connect4_pkg::*;

    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int START = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       press_izq, press_der, press_ent, jugada;
    logic       btn_enable, player, drop_err, turn_done, board_full;
    logic [2:0] cursor_col;
    logic [6:0] col_full;
`ifdef TURN_TIMEOUT_EN
    logic       timeout;
`endif

    control_columna_if #(.ROWS(ROWS), .COLS(COLS)) wr_if ();

    control_columna #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .START_COL (START)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .press_izq  (press_izq),
        .press_der  (press_der),
        .press_ent  (press_ent),
        .jugada     (jugada),
        .btn_enable (btn_enable),
        .cursor_col (cursor_col),
        .player     (player),
        .wr         (wr_if),
        .col_full   (col_full),
        .drop_err   (drop_err),
        .turn_done  (turn_done),
`ifdef TURN_TIMEOUT_EN
        .timeout    (timeout),
`endif
        .board_full (board_full)
    );

    always #5 clk = ~clk;

    // Behavioural board model
    int m_cursor, m_player, m_count;
    int m_height [COLS];
    bit m_full;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit izq, input bit der, input bit ent, input bit jug);
        press_izq = izq;
        press_der = der;
        press_ent = ent;
        jugada    = jug;
        step();
        press_izq = 1'b0;
        press_der = 1'b0;
        press_ent = 1'b0;
        jugada    = 1'b0;
    endtask

    task automatic model_reset();
        m_cursor = START;
        m_player = 0;
        m_count  = 0;
        m_full   = 1'b0;
        for (int c = 0; c < COLS; c++) m_height[c] = 0;
    endtask

    function automatic logic [6:0] full_mask();
        logic [6:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++) m[c] = (m_height[c] == ROWS);
        return m;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cursor"}, 32'(cursor_col), START);
        chk({tag, "_player"}, 32'(player), 0);
        chk({tag, "_wr_valid"}, 32'(wr_if.wr_valid), 0);
        chk({tag, "_wr_row"}, 32'(wr_if.wr_row), 0);
        chk({tag, "_wr_col"}, 32'(wr_if.wr_col), 0);
        chk({tag, "_wr_player"}, 32'(wr_if.wr_player), 0);
        chk({tag, "_col_full"}, 32'(col_full), 0);
        chk({tag, "_drop_err"}, 32'(drop_err), 0);
        chk({tag, "_turn_done"}, 32'(turn_done), 0);
        chk({tag, "_board_full"}, 32'(board_full), 0);
        chk({tag, "_btn_enable"}, 32'(btn_enable), 1);
    endtask

    // One move attempt, checked against the model; stall = cycles wr_ready is held low.
    task automatic act(input bit izq, input bit der, input bit ent, input bit jug, input int stall);
        if (!jug || m_full || !(izq || der || ent)) begin
            press(izq, der, ent, jug);
            chk("ignored_cursor", 32'(cursor_col), m_cursor);
            chk("ignored_wr_valid", 32'(wr_if.wr_valid), 0);
            chk("ignored_drop_err", 32'(drop_err), 0);
            chk("ignored_player", 32'(player), m_player);
        end else if (izq) begin
            press(izq, der, ent, jug);
            m_cursor = (m_cursor == 0) ? COLS - 1 : m_cursor - 1;
            chk("izq_cursor", 32'(cursor_col), m_cursor);
        end else if (der) begin
            press(izq, der, ent, jug);
            m_cursor = (m_cursor == COLS - 1) ? 0 : m_cursor + 1;
            chk("der_cursor", 32'(cursor_col), m_cursor);
        end else if (m_height[m_cursor] == ROWS) begin
            press(0, 0, 1, 1);
            chk("full_drop_err", 32'(drop_err), 1);
            chk("full_wr_valid", 32'(wr_if.wr_valid), 0);
            chk("full_btn_enable", 32'(btn_enable), 1);
            step();
            chk("full_drop_err_pulse", 32'(drop_err), 0);
            chk("full_player", 32'(player), m_player);
            chk("full_cursor", 32'(cursor_col), m_cursor);
        end else begin
            wr_if.wr_ready = (stall == 0);
            press(0, 0, 1, 1);
            chk("drop_wr_valid", 32'(wr_if.wr_valid), 1);
            chk("drop_wr_col", 32'(wr_if.wr_col), m_cursor);
            chk("drop_wr_row", 32'(wr_if.wr_row), m_height[m_cursor]);
            chk("drop_wr_player", 32'(wr_if.wr_player), m_player);
            chk("drop_btn_enable", 32'(btn_enable), 0);
            for (int i = 0; i < stall; i++) begin
                press(1, 0, 1, 1);
                chk("stall_wr_valid", 32'(wr_if.wr_valid), 1);
                chk("stall_wr_row", 32'(wr_if.wr_row), m_height[m_cursor]);
                chk("stall_wr_col", 32'(wr_if.wr_col), m_cursor);
                chk("stall_btn_enable", 32'(btn_enable), 0);
                chk("stall_cursor", 32'(cursor_col), m_cursor);
            end
            wr_if.wr_ready = 1'b1;
            step();
            m_height[m_cursor]++;
            m_count++;
            chk("hs_wr_valid_drop", 32'(wr_if.wr_valid), 0);
            chk("hs_turn_done_early", 32'(turn_done), 0);
            step();
            m_player = 1 - m_player;
            m_full   = (m_count == ROWS * COLS);
            chk("turn_done", 32'(turn_done), 1);
            chk("turn_player", 32'(player), m_player);
            chk("turn_board_full", 32'(board_full), 32'(m_full));
            chk("turn_btn_enable", 32'(btn_enable), 32'(!m_full));
            chk("turn_cursor", 32'(cursor_col), m_cursor);
            chk("turn_col_full", 32'(col_full), 32'(full_mask()));
`ifdef TURN_TIMEOUT_EN
            chk("turn_timeout", 32'(timeout), 0);
`endif
            step();
            chk("turn_done_pulse", 32'(turn_done), 0);
        end
    endtask

    initial begin
        bit r_izq, r_der, r_ent, r_jug;
        int r;

        reset = 1'b1;
        press_izq = 1'b0;
        press_der = 1'b0;
        press_ent = 1'b0;
        jugada    = 1'b0;
        wr_if.wr_ready = 1'b1;
        model_reset();
        step();
        step();
        chk_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Left wrap
        for (int i = 0; i < 4; i++) act(1, 0, 0, 1, 0);
        chk("izq_wrap_to_6", 32'(cursor_col), 6);
        chk("izq_player", 32'(player), 0);

        // Right wrap and jugada qualification
        act(0, 1, 0, 1, 0);
        chk("der_wrap_to_0", 32'(cursor_col), 0);
        act(0, 1, 0, 0, 0);
        chk("der_no_jugada", 32'(cursor_col), 0);

        // First drop on column 3, then a stalled drop on the same column
        for (int i = 0; i < 3; i++) act(0, 1, 0, 1, 0);
        act(0, 0, 1, 1, 0);
        chk("first_drop_player", 32'(player), 1);
        act(0, 0, 1, 1, 5);
        chk("stalled_drop_player", 32'(player), 0);

        // Fill column 0, then an enter on it
        for (int i = 0; i < 3; i++) act(1, 0, 0, 1, 0);
        for (int i = 0; i < ROWS; i++) act(0, 0, 1, 1, 0);
        chk("col0_full", 32'(col_full[0]), 1);
        act(0, 0, 1, 1, 0);

        // Randomized play until the board is full
        for (int it = 0; it < 4000 && !m_full; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 9) begin
                r_jug = 1'b0;
                r_izq = 1'($urandom_range(0, 1));
                r_der = 1'($urandom_range(0, 1));
                r_ent = 1'($urandom_range(0, 1));
            end else begin
                r_jug = 1'b1;
                r_izq = (r < 3);
                r_der = (r >= 3 && r < 6) || (r < 3 && 1'($urandom_range(0, 1)));
                r_ent = (r >= 6) || (r < 6 && 1'($urandom_range(0, 1)));
            end
            act(r_izq, r_der, r_ent, r_jug, int'($urandom_range(0, 3)));
        end
        chk("board_full_after_fill", 32'(board_full), 1);
        chk("btn_enable_after_fill", 32'(btn_enable), 0);
        chk("col_full_after_fill", 32'(col_full), 32'h7f);
        act(0, 0, 1, 1, 0);
        act(0, 1, 0, 1, 0);
        chk("full_sticky", 32'(board_full), 1);

        // Reset abandons a pending write on a fresh game
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        step();
        chk_reset_outputs("fresh");
        wr_if.wr_ready = 1'b0;
        press(0, 0, 1, 1);
        chk("midwrite_wr_valid", 32'(wr_if.wr_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midwrite_reset");
        step();
        reset = 1'b0;
        wr_if.wr_ready = 1'b1;
        step();
        chk_reset_outputs("after_midwrite");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
